// File: rtl/tytra_math_pkg.sv
// Shared helpers for the pipelined math cores: stage count and slice-width legality.
package tytra_math_pkg;

   // Number of pipeline stages when a word of n bits is cut into chunk-bit slices.
   function automatic int stage_count(input int n, input int chunk);
      return (chunk > 0) ? (n / chunk) : 1;
   endfunction

   // A width is legal only if it splits into a whole number of non-empty slices.
   function automatic bit chunk_fits(input int n, input int chunk);
      return (chunk > 0) && (n >= chunk) && ((n % chunk) == 0);
   endfunction

endpackage

// File: rtl/ui_sub_stage.sv
// One pipeline slice: subtract slice S with the incoming borrow, forward
// the remaining operand slices and lower result slices, and hold a valid bit.
module ui_sub_stage
   import tytra_math_pkg::*;
#(
   parameter int N     = 64,
   parameter int CHUNK = 16,
   parameter int S     = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         up_valid,
   input  logic [N-1:0] a_in,
   input  logic [N-1:0] b_in,
   input  logic [N-1:0] res_in,
   input  logic         br_in,
   input  logic         down_load,
   output logic         load,
   output logic         valid,
   output logic [N-1:0] a_out,
   output logic [N-1:0] b_out,
   output logic [N-1:0] res_out,
   output logic         br_out
);

   localparam int LSB = S * CHUNK;

   logic         v_q, v_d;
   logic [N-1:0] a_q, a_d;
   logic [N-1:0] b_q, b_d;
   logic [N-1:0] res_q, res_d;
   logic         br_q, br_d;
   logic [CHUNK:0] diff;

   // A stage may take new contents when it is empty or its contents move on.
   assign load = !v_q || down_load;

   // Slice subtract with borrow; the extra MSB of the wide difference is the borrow out.
   always_comb begin
      diff  = {1'b0, a_in[LSB +: CHUNK]} - {1'b0, b_in[LSB +: CHUNK]}
              - {{CHUNK{1'b0}}, br_in};
      v_d   = v_q;
      a_d   = a_q;
      b_d   = b_q;
      res_d = res_q;
      br_d  = br_q;
      if (load) begin
         v_d                 = up_valid;
         a_d                 = a_in;
         b_d                 = b_in;
         res_d               = res_in;
         res_d[LSB +: CHUNK] = diff[CHUNK-1:0];
         br_d                = diff[CHUNK];
      end
   end

   // Stage registers; data may load with a bubble, but the valid bit tracks it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q   <= 1'b0;
         a_q   <= '0;
         b_q   <= '0;
         res_q <= '0;
         br_q  <= 1'b0;
      end else begin
         v_q   <= v_d;
         a_q   <= a_d;
         b_q   <= b_d;
         res_q <= res_d;
         br_q  <= br_d;
      end
   end

   assign valid   = v_q;
   assign a_out   = a_q;
   assign b_out   = b_q;
   assign res_out = res_q;
   assign br_out  = br_q;

endmodule

// File: rtl/ui_sub_pipe.sv
// Pipelined unsigned subtractor c = a - b with borrow-out, one CHUNK-bit
// slice per stage and valid/ready handshakes on both sides.
module ui_sub_pipe
   import tytra_math_pkg::*;
#(
   parameter int N     = 64,
   parameter int CHUNK = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] c,
   output logic         borrow
);

   localparam int STAGES = stage_count(N, CHUNK);

   if (!chunk_fits(N, CHUNK)) begin : g_bad_cfg
      $fatal(1, "ui_sub_pipe: N must be a non-zero multiple of CHUNK");
   end

   genvar gi;
   for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic         up_v, br_i, dn_ld;
      logic [N-1:0] a_i, b_i, res_i;
      logic         ld, v, br_o;
      logic [N-1:0] a_o, b_o, res_o;

      if (gi == 0) begin : g_first
         assign up_v  = in_valid;
         assign a_i   = a;
         assign b_i   = b;
         assign res_i = '0;
         assign br_i  = 1'b0;
      end else begin : g_chain
         assign up_v  = g_stage[gi-1].v;
         assign a_i   = g_stage[gi-1].a_o;
         assign b_i   = g_stage[gi-1].b_o;
         assign res_i = g_stage[gi-1].res_o;
         assign br_i  = g_stage[gi-1].br_o;
      end

      if (gi == STAGES - 1) begin : g_last
         logic [N-1:0] unused_ab;
         assign dn_ld     = out_ready;
         assign unused_ab = a_o ^ b_o;
      end else begin : g_inner
         assign dn_ld = g_stage[gi+1].ld;
      end

      ui_sub_stage #(
         .N     (N),
         .CHUNK (CHUNK),
         .S     (gi)
      ) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .up_valid  (up_v),
         .a_in      (a_i),
         .b_in      (b_i),
         .res_in    (res_i),
         .br_in     (br_i),
         .down_load (dn_ld),
         .load      (ld),
         .valid     (v),
         .a_out     (a_o),
         .b_out     (b_o),
         .res_out   (res_o),
         .br_out    (br_o)
      );
   end

   assign in_ready  = g_stage[0].ld;
   assign out_valid = g_stage[STAGES-1].v;
   assign c         = g_stage[STAGES-1].res_o;
   assign borrow    = g_stage[STAGES-1].br_o;

endmodule
